// File: rtl/cva6_load_tracker_if.sv
// Load-unit / data-cache handshake bundle for cva6_load_tracker.
// The master drives requests and responses; the slave is the tracker itself.
interface cva6_load_tracker_if #(
   parameter int TID_WIDTH    = 4,
   parameter int XLEN         = 32,
   parameter int SBE_ID_WIDTH = 2,
   parameter int TAG_WIDTH    = 1
);
   localparam int OFF_W = $clog2(XLEN / 8);
   localparam int TAG_W = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;

   logic                    flush_i;
   logic                    req_valid_i;
   logic                    req_ready_o;
   logic [SBE_ID_WIDTH-1:0] req_sbe_id_i;
   logic [OFF_W-1:0]        req_offset_i;
   logic [1:0]              req_size_i;
   logic                    req_signed_i;
   logic [TID_WIDTH-1:0]    req_tid_o;
   logic                    rsp_valid_i;
   logic [TID_WIDTH-1:0]    rsp_tid_i;
   logic [XLEN-1:0]         rsp_data_i;
   logic [TAG_W-1:0]        rsp_tag_i;
   logic                    wb_valid_o;
   logic [SBE_ID_WIDTH-1:0] wb_sbe_id_o;
   logic [XLEN-1:0]         wb_data_o;
   logic [TAG_W-1:0]        wb_tag_o;
   logic                    busy_o;
   logic                    err_o;

   modport master (
      output flush_i, req_valid_i, req_sbe_id_i, req_offset_i, req_size_i, req_signed_i,
      output rsp_valid_i, rsp_tid_i, rsp_data_i, rsp_tag_i,
      input  req_ready_o, req_tid_o, wb_valid_o, wb_sbe_id_o, wb_data_o, wb_tag_o,
      input  busy_o, err_o
   );

   modport slave (
      input  flush_i, req_valid_i, req_sbe_id_i, req_offset_i, req_size_i, req_signed_i,
      input  rsp_valid_i, rsp_tid_i, rsp_data_i, rsp_tag_i,
      output req_ready_o, req_tid_o, wb_valid_o, wb_sbe_id_o, wb_data_o, wb_tag_o,
      output busy_o, err_o
   );
endinterface

// File: rtl/cva6_load_tracker.sv
// Outstanding-load tracker: allocates IDs, matches out-of-order cache responses,
// aligns/extends data. Optional occupancy ports: CVA6_LOAD_TRACKER_OCCUPANCY_EN.
module cva6_load_tracker #(
   parameter int NR_ENTRIES   = 2,
   parameter int TID_WIDTH    = 4,
   parameter int XLEN         = 32,
   parameter int SBE_ID_WIDTH = 2,
   parameter int TAG_WIDTH    = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   cva6_load_tracker_if.slave  bus
`ifdef CVA6_LOAD_TRACKER_OCCUPANCY_EN
   ,
   output logic [$clog2(NR_ENTRIES+1)-1:0] occupancy_o,
   output logic [$clog2(NR_ENTRIES+1)-1:0] high_water_o
`endif
);
   localparam int OFF_W = $clog2(XLEN / 8);
   localparam int TAG_W = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;
   localparam int CNT_W = $clog2(NR_ENTRIES + 1);

   function automatic int width_of(input logic [1:0] size);
      int w;
      w = 8 << size;
      if (w > XLEN) w = XLEN;
      return w;
   endfunction

   function automatic logic [XLEN-1:0] align_data(input logic [XLEN-1:0] raw,
                                                  input logic [OFF_W-1:0] off,
                                                  input logic [1:0] size,
                                                  input logic sgn);
      logic [XLEN-1:0] sh;
      logic [XLEN-1:0] res;
      logic            fill;
      int              nbits;
      sh    = raw >> {off, 3'b000};
      nbits = width_of(size);
      fill  = sgn & sh[nbits-1];
      for (int i = 0; i < XLEN; i++) res[i] = (i < nbits) ? sh[i] : fill;
      return res;
   endfunction

   logic [NR_ENTRIES-1:0]   valid_q, valid_d, killed_q, killed_d, hit;
   logic [SBE_ID_WIDTH-1:0] sbe_q  [NR_ENTRIES];
   logic [OFF_W-1:0]        off_q  [NR_ENTRIES];
   logic [1:0]              size_q [NR_ENTRIES];
   logic                    sgn_q  [NR_ENTRIES];
   logic [TID_WIDTH-1:0]    free_idx, last_tid_q;
   logic                    any_free, alloc, good;
   logic [SBE_ID_WIDTH-1:0] hit_sbe;
   logic [OFF_W-1:0]        hit_off;
   logic [1:0]              hit_size;
   logic                    hit_sgn, hit_killed;
   logic                    wb_valid_p1, err_p1;
   logic [SBE_ID_WIDTH-1:0] wb_sbe_p1;
   logic [XLEN-1:0]         wb_data_p1;
   logic [TAG_W-1:0]        wb_tag_p1;

   // Allocation uses only the registered valid vector, so a slot freed this
   // cycle cannot be handed out until the next one.
   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            any_free = 1'b1;
            free_idx = TID_WIDTH'(i);
         end
      end
   end

   assign bus.req_ready_o = !bus.flush_i && any_free;
   assign bus.req_tid_o   = any_free ? free_idx : last_tid_q;
   assign alloc           = bus.req_valid_i && bus.req_ready_o;

   always_comb begin
      hit        = '0;
      hit_sbe    = '0;
      hit_off    = '0;
      hit_size   = '0;
      hit_sgn    = 1'b0;
      hit_killed = 1'b0;
      for (int i = 0; i < NR_ENTRIES; i++) begin
         if (bus.rsp_valid_i && bus.rsp_tid_i == TID_WIDTH'(i) && valid_q[i]) begin
            hit[i]     = 1'b1;
            hit_sbe    = sbe_q[i];
            hit_off    = off_q[i];
            hit_size   = size_q[i];
            hit_sgn    = sgn_q[i];
            hit_killed = killed_q[i];
         end
      end
   end
   assign good = |hit;

   always_comb begin
      valid_d  = valid_q;
      killed_d = killed_q;
      for (int i = 0; i < NR_ENTRIES; i++) begin
         if (alloc && free_idx == TID_WIDTH'(i)) begin
            valid_d[i]  = 1'b1;
            killed_d[i] = 1'b0;
         end else if (hit[i]) begin
            valid_d[i]  = 1'b0;
            killed_d[i] = 1'b0;
         end else if (bus.flush_i && valid_q[i]) begin
            killed_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q    <= '0;
         killed_q   <= '0;
         last_tid_q <= '0;
      end else begin
         valid_q  <= valid_d;
         killed_q <= killed_d;
         if (any_free) last_tid_q <= free_idx;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
         if (alloc && free_idx == TID_WIDTH'(i)) begin
            sbe_q[i]  <= bus.req_sbe_id_i;
            off_q[i]  <= bus.req_offset_i;
            size_q[i] <= bus.req_size_i;
            sgn_q[i]  <= bus.req_signed_i;
         end
      end
   end

   // p0 -> p1: response matched this cycle, writeback/error registered.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb_valid_p1 <= 1'b0;
         err_p1      <= 1'b0;
         wb_sbe_p1   <= '0;
         wb_data_p1  <= '0;
         wb_tag_p1   <= '0;
      end else begin
         wb_valid_p1 <= good && !hit_killed;
         err_p1      <= bus.rsp_valid_i && !good;
         if (good && !hit_killed) begin
            wb_sbe_p1  <= hit_sbe;
            wb_data_p1 <= align_data(bus.rsp_data_i, hit_off, hit_size, hit_sgn);
            wb_tag_p1  <= (TAG_WIDTH > 0 && width_of(hit_size) == XLEN && hit_off == '0)
                          ? bus.rsp_tag_i : '0;
         end
      end
   end

   assign bus.wb_valid_o  = wb_valid_p1;
   assign bus.wb_sbe_id_o = wb_sbe_p1;
   assign bus.wb_data_o   = wb_data_p1;
   assign bus.wb_tag_o    = wb_tag_p1;
   assign bus.err_o       = err_p1;
   assign bus.busy_o      = |valid_q;

`ifdef CVA6_LOAD_TRACKER_OCCUPANCY_EN
   function automatic logic [CNT_W-1:0] popcount(input logic [NR_ENTRIES-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < NR_ENTRIES; i++) if (v[i]) c = c + CNT_W'(1);
      return c;
   endfunction

   logic [CNT_W-1:0] occ_q, hw_q, occ_d;
   assign occ_d = popcount(valid_d);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         occ_q <= '0;
         hw_q  <= '0;
      end else begin
         occ_q <= occ_d;
         if (occ_d > hw_q) hw_q <= occ_d;
      end
   end

   assign occupancy_o  = occ_q;
   assign high_water_o = hw_q;
`endif
endmodule

// File: tb/tb_cva6_load_tracker.sv
// Directed bench for cva6_load_tracker (NR_ENTRIES=2, XLEN=32): allocation,
// out-of-order completion, alignment, tag forwarding, flush, full, bad ID, reset.
module tb_cva6_load_tracker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   cva6_load_tracker_if #(.TID_WIDTH(4), .XLEN(32), .SBE_ID_WIDTH(2), .TAG_WIDTH(1)) bus ();

`ifdef CVA6_LOAD_TRACKER_OCCUPANCY_EN
   logic [1:0] occupancy, high_water;
`endif

   cva6_load_tracker #(.NR_ENTRIES(2), .TID_WIDTH(4), .XLEN(32), .SBE_ID_WIDTH(2), .TAG_WIDTH(1)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
`ifdef CVA6_LOAD_TRACKER_OCCUPANCY_EN
      ,
      .occupancy_o  (occupancy),
      .high_water_o (high_water)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush_i      = 1'b0;
      bus.req_valid_i  = 1'b0;
      bus.req_sbe_id_i = '0;
      bus.req_offset_i = '0;
      bus.req_size_i   = '0;
      bus.req_signed_i = 1'b0;
      bus.rsp_valid_i  = 1'b0;
      bus.rsp_tid_i    = '0;
      bus.rsp_data_i   = '0;
      bus.rsp_tag_i    = '0;
   endtask

   task automatic drive_req(input logic [1:0] sbe, input logic [1:0] off,
                            input logic [1:0] size, input logic sgn);
      bus.req_valid_i  = 1'b1;
      bus.req_sbe_id_i = sbe;
      bus.req_offset_i = off;
      bus.req_size_i   = size;
      bus.req_signed_i = sgn;
   endtask

   task automatic drive_rsp(input logic [3:0] tid, input logic [31:0] data, input logic tag);
      bus.rsp_valid_i = 1'b1;
      bus.rsp_tid_i   = tid;
      bus.rsp_data_i  = data;
      bus.rsp_tag_i   = tag;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
      tests++; if (bus.req_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o); end
      tests++; if (bus.req_tid_o !== 4'd0) begin fails++; $display("FAIL reset_tid: got %0d want 0", bus.req_tid_o); end
      tests++; if ({bus.wb_valid_o, bus.err_o} !== 2'b00) begin fails++; $display("FAIL reset_wb_err: got %b want 00", {bus.wb_valid_o, bus.err_o}); end
      tests++; if (bus.wb_data_o !== 32'h0 || bus.wb_sbe_id_o !== 2'd0 || bus.wb_tag_o !== 1'b0) begin fails++; $display("FAIL reset_wb_fields: data %h sbe %0d tag %b want 0", bus.wb_data_o, bus.wb_sbe_id_o, bus.wb_tag_o); end
`ifdef CVA6_LOAD_TRACKER_OCCUPANCY_EN
      tests++; if (occupancy !== 2'd0 || high_water !== 2'd0) begin fails++; $display("FAIL reset_occ: occ %0d hw %0d want 0 0", occupancy, high_water); end
`endif
   endtask

   task automatic test_alloc_and_out_of_order();
      drive_req(2'd1, 2'd0, 2'd2, 1'b0);
      tests++; if (bus.req_tid_o !== 4'd0) begin fails++; $display("FAIL alloc0_tid: got %0d want 0", bus.req_tid_o); end
      tick();
`ifdef CVA6_LOAD_TRACKER_OCCUPANCY_EN
      tests++; if (occupancy !== 2'd1) begin fails++; $display("FAIL occ_1: got %0d want 1", occupancy); end
`endif
      drive_req(2'd2, 2'd2, 2'd0, 1'b1);
      tests++; if (bus.req_tid_o !== 4'd1) begin fails++; $display("FAIL alloc1_tid: got %0d want 1", bus.req_tid_o); end
      tick();
      idle();
      tests++; if (bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", bus.req_ready_o); end
      tests++; if (bus.req_tid_o !== 4'd1) begin fails++; $display("FAIL full_tid_hold: got %0d want 1", bus.req_tid_o); end
      tests++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL full_busy: got %b want 1", bus.busy_o); end
`ifdef CVA6_LOAD_TRACKER_OCCUPANCY_EN
      tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL occ_2: got %0d want 2", occupancy); end
`endif
      drive_rsp(4'd1, 32'h8080_1234, 1'b1);
      tick();
      idle();
      tests++; if (bus.wb_valid_o !== 1'b1) begin fails++; $display("FAIL ooo1_valid: got %b want 1", bus.wb_valid_o); end
      tests++; if (bus.wb_sbe_id_o !== 2'd2) begin fails++; $display("FAIL ooo1_sbe: got %0d want 2", bus.wb_sbe_id_o); end
      tests++; if (bus.wb_data_o !== 32'hFFFF_FF80) begin fails++; $display("FAIL ooo1_data: got %h want ffffff80", bus.wb_data_o); end
      tests++; if (bus.wb_tag_o !== 1'b0) begin fails++; $display("FAIL ooo1_tag: got %b want 0", bus.wb_tag_o); end
`ifdef CVA6_LOAD_TRACKER_OCCUPANCY_EN
      tests++; if (occupancy !== 2'd1 || high_water !== 2'd2) begin fails++; $display("FAIL occ_after_rsp: occ %0d hw %0d want 1 2", occupancy, high_water); end
`endif
      drive_rsp(4'd0, 32'h8080_1234, 1'b1);
      tick();
      idle();
      tests++; if (bus.wb_valid_o !== 1'b1 || bus.wb_sbe_id_o !== 2'd1) begin fails++; $display("FAIL ooo0_valid_sbe: got %b/%0d want 1/1", bus.wb_valid_o, bus.wb_sbe_id_o); end
      tests++; if (bus.wb_data_o !== 32'h8080_1234) begin fails++; $display("FAIL ooo0_data: got %h want 80801234", bus.wb_data_o); end
      tests++; if (bus.wb_tag_o !== 1'b1) begin fails++; $display("FAIL ooo0_tag: got %b want 1", bus.wb_tag_o); end
      tick();
      tests++; if (bus.wb_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin fails++; $display("FAIL ooo_drain: wb %b busy %b want 0 0", bus.wb_valid_o, bus.busy_o); end
   endtask

   task automatic test_tag_clear();
      drive_req(2'd3, 2'd0, 2'd1, 1'b0);
      tick();
      idle();
      drive_rsp(4'd0, 32'h0000_F00D, 1'b1);
      tick();
      idle();
      tests++; if (bus.wb_valid_o !== 1'b1 || bus.wb_sbe_id_o !== 2'd3) begin fails++; $display("FAIL half_valid_sbe: got %b/%0d want 1/3", bus.wb_valid_o, bus.wb_sbe_id_o); end
      tests++; if (bus.wb_data_o !== 32'h0000_F00D) begin fails++; $display("FAIL half_unsigned_data: got %h want 0000f00d", bus.wb_data_o); end
      tests++; if (bus.wb_tag_o !== 1'b0) begin fails++; $display("FAIL half_tag_clear: got %b want 0", bus.wb_tag_o); end
      // signed halfword at offset 2
      drive_req(2'd0, 2'd2, 2'd1, 1'b1);
      tick();
      idle();
      drive_rsp(4'd0, 32'hBEEF_0001, 1'b1);
      tick();
      idle();
      tests++; if (bus.wb_data_o !== 32'hFFFF_BEEF) begin fails++; $display("FAIL half_signed_data: got %h want ffffbeef", bus.wb_data_o); end
   endtask

   task automatic test_flush();
      drive_req(2'd0, 2'd0, 2'd2, 1'b0);
      tick();
      drive_req(2'd1, 2'd0, 2'd2, 1'b0);
      tick();
      idle();
      bus.flush_i = 1'b1;
      tests++; if (bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b want 0", bus.req_ready_o); end
      tick();
      idle();
      drive_rsp(4'd0, 32'h1111_1111, 1'b0);
      tick();
      idle();
      tests++; if (bus.wb_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin fails++; $display("FAIL flush_rsp0: wb %b busy %b want 0 1", bus.wb_valid_o, bus.busy_o); end
      drive_rsp(4'd1, 32'h2222_2222, 1'b0);
      tick();
      idle();
      tests++; if (bus.wb_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin fails++; $display("FAIL flush_rsp1: wb %b busy %b want 0 0", bus.wb_valid_o, bus.busy_o); end
      tests++; if (bus.req_ready_o !== 1'b1 || bus.err_o !== 1'b0) begin fails++; $display("FAIL flush_after: ready %b err %b want 1 0", bus.req_ready_o, bus.err_o); end
      // a response landing in the flush cycle still writes back
      drive_req(2'd2, 2'd0, 2'd2, 1'b0);
      tick();
      idle();
      bus.flush_i = 1'b1;
      drive_rsp(4'd0, 32'h3333_4444, 1'b0);
      tick();
      idle();
      tests++; if (bus.wb_valid_o !== 1'b1 || bus.wb_data_o !== 32'h3333_4444) begin fails++; $display("FAIL flush_same_cycle: wb %b data %h want 1 33334444", bus.wb_valid_o, bus.wb_data_o); end
      tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL flush_same_cycle_busy: got %b want 0", bus.busy_o); end
   endtask

   task automatic test_full_simultaneous();
      drive_req(2'd0, 2'd0, 2'd2, 1'b0);
      tick();
      drive_req(2'd1, 2'd0, 2'd2, 1'b0);
      tick();
      idle();
      drive_rsp(4'd0, 32'hAAAA_5555, 1'b0);
      drive_req(2'd3, 2'd0, 2'd2, 1'b0);
      tests++; if (bus.req_ready_o !== 1'b0 || bus.req_tid_o !== 4'd1) begin fails++; $display("FAIL simul_blocked: ready %b tid %0d want 0 1", bus.req_ready_o, bus.req_tid_o); end
      tick();
      idle();
      tests++; if (bus.req_ready_o !== 1'b1 || bus.req_tid_o !== 4'd0) begin fails++; $display("FAIL simul_after: ready %b tid %0d want 1 0", bus.req_ready_o, bus.req_tid_o); end
      tests++; if (bus.wb_valid_o !== 1'b1 || bus.wb_sbe_id_o !== 2'd0) begin fails++; $display("FAIL simul_wb: wb %b sbe %0d want 1 0", bus.wb_valid_o, bus.wb_sbe_id_o); end
      drive_rsp(4'd1, 32'h0, 1'b0);
      tick();
      idle();
      tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL simul_drain: busy %b want 0", bus.busy_o); end
   endtask

   task automatic test_bad_id();
      drive_req(2'd2, 2'd0, 2'd2, 1'b0);
      tick();
      idle();
      drive_rsp(4'd3, 32'hDEAD_BEEF, 1'b1);
      tick();
      idle();
      tests++; if (bus.err_o !== 1'b1 || bus.wb_valid_o !== 1'b0) begin fails++; $display("FAIL bad_id_pulse: err %b wb %b want 1 0", bus.err_o, bus.wb_valid_o); end
      tick();
      tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL bad_id_one_cycle: err %b want 0", bus.err_o); end
      tests++; if (bus.busy_o !== 1'b1 || bus.req_tid_o !== 4'd1) begin fails++; $display("FAIL bad_id_state: busy %b tid %0d want 1 1", bus.busy_o, bus.req_tid_o); end
      drive_rsp(4'd1, 32'h0, 1'b0);
      tick();
      idle();
      tests++; if (bus.err_o !== 1'b1 || bus.wb_valid_o !== 1'b0) begin fails++; $display("FAIL invalid_entry: err %b wb %b want 1 0", bus.err_o, bus.wb_valid_o); end
      drive_rsp(4'd0, 32'h0000_0042, 1'b0);
      tick();
      idle();
      tests++; if (bus.wb_valid_o !== 1'b1 || bus.err_o !== 1'b0 || bus.wb_sbe_id_o !== 2'd2) begin fails++; $display("FAIL bad_id_recover: wb %b err %b sbe %0d want 1 0 2", bus.wb_valid_o, bus.err_o, bus.wb_sbe_id_o); end
   endtask

   task automatic test_reset_mid();
      drive_req(2'd1, 2'd0, 2'd2, 1'b0);
      tick();
      drive_req(2'd2, 2'd0, 2'd2, 1'b0);
      tick();
      idle();
      drive_rsp(4'd0, 32'h1234_5678, 1'b1);
      tick();
      idle();
      tests++; if (bus.wb_valid_o !== 1'b1) begin fails++; $display("FAIL pre_reset_wb: got %b want 1", bus.wb_valid_o); end
      rst = 1'b1;
      #1;
      tests++; if (bus.wb_valid_o !== 1'b0 || bus.wb_data_o !== 32'h0 || bus.wb_tag_o !== 1'b0) begin fails++; $display("FAIL mid_reset_wb: wb %b data %h tag %b want 0", bus.wb_valid_o, bus.wb_data_o, bus.wb_tag_o); end
      tests++; if (bus.busy_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.req_tid_o !== 4'd0) begin fails++; $display("FAIL mid_reset_ctrl: busy %b ready %b tid %0d want 0 1 0", bus.busy_o, bus.req_ready_o, bus.req_tid_o); end
`ifdef CVA6_LOAD_TRACKER_OCCUPANCY_EN
      tests++; if (occupancy !== 2'd0 || high_water !== 2'd0) begin fails++; $display("FAIL mid_reset_occ: occ %0d hw %0d want 0 0", occupancy, high_water); end
`endif
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      idle();
      test_reset();
      test_alloc_and_out_of_order();
      test_tag_clear();
      test_flush();
      test_full_simultaneous();
      test_bad_id();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got no summary want summary");
      $fatal(1);
   end
endmodule

// File: doc/cva6_load_tracker.md
Name: cva6_load_tracker

Overview:
- Parametrised outstanding-load tracker between the load unit and the data-cache request/response port.
- Allocates a transaction ID per issued load and stores the per-load metadata.
- Matches out-of-order cache responses by ID, then aligns and sign-extends the returned data and forwards the capability tag.
- Successor to the fixed 2-entry load buffer: depth, ID width, XLEN and tag width are generic; adds flush/kill handling and an error report for a bad ID.

Parameters:
- NR_ENTRIES, 2, number of outstanding loads tracked (1..2**TID_WIDTH).
- TID_WIDTH, 4, width of the memory transaction ID.
- XLEN, 32, data width (32 or 64).
- SBE_ID_WIDTH, 2, scoreboard entry ID width.
- TAG_WIDTH, 1, capability tag width (0 allowed: tag ports tied to 0).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  kill all outstanding loads
- req_valid_i  in  1  load issued
- req_ready_o  out  1  a free entry exists and no flush this cycle
- req_sbe_id_i  in  SBE_ID_WIDTH  scoreboard ID of the load
- req_offset_i  in  $clog2(XLEN/8)  byte offset within the word
- req_size_i  in  2  0=B, 1=H, 2=W, 3=D (D only when XLEN=64)
- req_signed_i  in  1  sign-extend the result
- req_tid_o  out  TID_WIDTH  allocated ID, valid with the handshake
- rsp_valid_i  in  1  cache response
- rsp_tid_i  in  TID_WIDTH  response ID
- rsp_data_i  in  XLEN  raw word
- rsp_tag_i  in  TAG_WIDTH  capability tag
- wb_valid_o  out  1  writeback pulse
- wb_sbe_id_o  out  SBE_ID_WIDTH  scoreboard ID
- wb_data_o  out  XLEN  aligned, extended data
- wb_tag_o  out  TAG_WIDTH  forwarded tag
- busy_o  out  1  any entry valid
- err_o  out  1  one-cycle pulse: response to an invalid ID

Behaviour:
- Reset: all entries invalid and not killed. wb_valid_o=0, wb_sbe_id_o=0, wb_data_o=0, wb_tag_o=0, err_o=0, busy_o=0, req_tid_o=0.
- Per-entry state: valid, killed, sbe_id, offset, size, signed.
- Allocation:
  - req_ready_o = !flush_i && (some entry invalid in the registered state).
  - req_tid_o = index of the lowest invalid entry, zero-extended, combinational.
  - Handshake is req_valid_i && req_ready_o; the entry becomes valid on the next edge.
- Response (rsp_valid_i, ID t < NR_ENTRIES with entry valid):
  - The entry is freed on the next edge.
  - If the entry is not killed: wb_valid_o=1 in the next cycle (latency 1, registered). There is no backpressure on writeback.
  - If killed: the entry is freed silently and wb_valid_o=0.
- Bad response (t >= NR_ENTRIES, or entry invalid): no state change, err_o=1 in the next cycle, wb_valid_o=0.
- Alignment:
  - shifted = rsp_data_i >> (offset*8); the result is truncated to 8<<size bits.
  - Upper bits are filled with the sign of the top kept bit if signed, else 0.
  - size=3 with XLEN=32 is treated as size=2.
- Tag: wb_tag_o = rsp_tag_i only when 8<<size == XLEN and offset==0; otherwise 0.
- A slot freed by a response is not allocatable until the following cycle (allocation uses the registered valid vector). Simultaneous allocate and free therefore never target the same entry.
- Flush: every valid entry gets killed=1 on the next edge, and no allocation happens in the flush cycle.
  - A response arriving in the flush cycle still produces its writeback (the response wins over the flush).
  - Killed entries stay busy until their response arrives.
- busy_o = OR of valid, registered.
- Full: with all NR_ENTRIES valid, req_ready_o=0 and req_tid_o holds its last value.

Optional Feature:
- Macro CVA6_LOAD_TRACKER_OCCUPANCY_EN.
- When defined, adds output occupancy_o [$clog2(NR_ENTRIES+1)] (count of valid entries, registered, reset 0) and output high_water_o of the same width.
  - high_water_o = maximum occupancy since reset; it saturates and clears only on rst_i.
- When undefined, neither port exists and there is no counter logic.

Test Plan:
- Reset, NR_ENTRIES=2 -> busy_o=0, req_ready_o=1, req_tid_o=0. Allocate sbe 1 -> tid 0; allocate sbe 2 -> tid 1; then req_ready_o=0.
- Out-of-order completion: rsp tid 1, data 0x8080_1234, offset 2, size 0, signed -> next cycle wb_sbe_id_o=2, wb_data_o=0xFFFF_FF80. Then tid 0, offset 0, size 2 -> wb_data_o=0x8080_1234 and wb_tag_o=rsp_tag_i=1.
- Tag clearing: size 1, offset 0, rsp_tag_i=1 -> wb_tag_o=0. Unsigned half 0x0000_F00D -> wb_data_o=0x0000_F00D.
- Flush with 2 outstanding: flush_i pulse; responses for tid 0 and 1 -> wb_valid_o never asserts, busy_o drops after the second response, req_ready_o=1.
- Full plus simultaneous free and request: with both entries valid, rsp tid 0 and req_valid_i in the same cycle -> request not accepted; next cycle req_ready_o=1, req_tid_o=0.
- Bad ID: rsp_tid_i=3 with NR_ENTRIES=2 -> err_o pulses for 1 cycle, wb_valid_o=0, state unchanged. Assert rst_i mid-stream -> all outputs return to reset values immediately. With CVA6_LOAD_TRACKER_OCCUPANCY_EN: occupancy_o follows 0,1,2,1, and high_water_o=2.
